// File: rtl/axil_master_arbiter_if.sv
// AXI4-Lite bus bundle between the requester arbiter and the
// register-file slave.
interface axil_master_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/axil_master_arbiter.sv
// Round-robin sharing of one AXI4-Lite master port between
// NUM_REQ single-beat requesters, with per-transaction timeout.
module axil_master_arbiter #(
  parameter int          NUM_REQ    = 4,
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic [1:0]                   rsp_resp,
  output logic                         rsp_timeout,
  axil_master_arbiter_if.master        m_axi
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW =
    (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [2:0] {
    IDLE, WADDR, WRESP, RADDR, RDATA
  } state_t;

  state_t                state, state_n;
  logic [IW-1:0]         last, idx, gnt_idx;
  logic                  gnt_found, grant;
  logic                  aw_done, w_done, abandoned;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [CW-1:0]         cnt;
  logic                  aw_v, w_v;
  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                  done, tmo;

  assign aw_v = (state == WADDR) && !aw_done;
  assign w_v  = (state == WADDR) && !w_done;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = aw_v;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = w_v;
  assign m_axi.bready  = (state == WRESP);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = (state == RADDR);
  assign m_axi.rready  = (state == RDATA);

  assign aw_hs = aw_v && m_axi.awready;
  assign w_hs  = w_v && m_axi.wready;
  assign b_hs  = (state == WRESP) && m_axi.bvalid;
  assign ar_hs = (state == RADDR) && m_axi.arready;
  assign r_hs  = (state == RDATA) && m_axi.rvalid;
  assign done  = b_hs || r_hs;

  // Count keeps running after abandonment; the flag
  // stops a second timeout pulse.
  assign tmo = (TIMEOUT != 0) && (state != IDLE) &&
               !abandoned && !done &&
               (cnt == CW'(TIMEOUT));

  // First pending requester above the last grant, wrapping.
  always_comb begin
    int            j;
    logic [IW-1:0] jj;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    jj        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(last) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IW'(j);
      if (!gnt_found && req_valid[jj]) begin
        gnt_found = 1'b1;
        gnt_idx   = jj;
      end
    end
  end

  assign grant = (state == IDLE) && gnt_found;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (gnt_found)
          state_n = req_we[gnt_idx] ? WADDR : RADDR;
      WADDR:
        if ((aw_done || aw_hs) && (w_done || w_hs))
          state_n = WRESP;
      WRESP:
        if (b_hs) state_n = IDLE;
      RADDR:
        if (ar_hs) state_n = RDATA;
      RDATA:
        if (r_hs) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= IDLE;
      last        <= IW'(NUM_REQ - 1);
      idx         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt         <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      abandoned   <= 1'b0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b00;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_timeout <= 1'b0;
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (state != IDLE) cnt <= cnt + CW'(1);
      if (grant) begin
        idx     <= gnt_idx;
        last    <= gnt_idx;
        addr_q  <= req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_q <= req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        cnt     <= '0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        req_ready[gnt_idx] <= 1'b1;
      end
      if (done) begin
        if (abandoned) begin
          abandoned <= 1'b0;
        end else begin
          rsp_valid[idx] <= 1'b1;
          rsp_resp  <= b_hs ? m_axi.bresp : m_axi.rresp;
          rsp_rdata <= b_hs ? '0 : m_axi.rdata;
        end
      end else if (tmo) begin
        abandoned      <= 1'b1;
        rsp_valid[idx] <= 1'b1;
        rsp_resp       <= 2'b10;
        rsp_rdata      <= '0;
        rsp_timeout    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Scoreboard bench for axil_master_arbiter with a
// configurable-latency AXI4-Lite register slave.
module tb_axil_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  axil_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi();

  axil_master_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .TIMEOUT(16)
  ) dut (
    .ACLK(clk), .ARESET(rst),
    .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout), .m_axi(axi)
  );

  always #5 clk = ~clk;

  // Slave model, evaluated on the falling edge
  logic [31:0] mem [0:15];
  int   aw_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0] rresp_cfg = 2'b00;
  int   aw_wait, b_wait, r_wait, b_count = 0;
  bit   aw_got, w_got, b_pend, r_pend;
  logic [31:0] aw_a, w_d, ar_a;

  always @(negedge clk) begin
    if (rst) begin
      axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
      axi.arready = 0; axi.rvalid = 0;
      axi.bresp = 0; axi.rresp = 0; axi.rdata = 0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      aw_wait = 0; b_wait = 0; r_wait = 0;
    end else begin
      axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
      axi.arready = 0; axi.rvalid = 0;
      if (axi.awvalid && !aw_got) begin
        if (aw_wait >= aw_delay) begin
          axi.awready = 1; aw_got = 1;
          aw_a = axi.awaddr; aw_wait = 0;
        end else aw_wait++;
      end
      if (axi.wvalid && !w_got) begin
        axi.wready = 1; w_got = 1; w_d = axi.wdata;
      end
      if (b_pend) begin
        if (b_wait >= b_delay) begin
          axi.bvalid = 1; axi.bresp = 2'b00;
          if (axi.bready) begin
            b_pend = 0; b_wait = 0; b_count++;
          end
        end else b_wait++;
      end
      if (aw_got && w_got) begin
        mem[aw_a[5:2]] = w_d;
        aw_got = 0; w_got = 0; b_pend = 1;
      end
      if (r_pend) begin
        if (r_wait >= r_delay) begin
          axi.rvalid = 1; axi.rresp = rresp_cfg;
          axi.rdata = mem[ar_a[5:2]];
          if (axi.rready) begin r_pend = 0; r_wait = 0; end
        end else r_wait++;
      end
      if (axi.arvalid && !r_pend) begin
        axi.arready = 1; ar_a = axi.araddr;
        r_pend = 1; r_wait = 0;
      end
    end
  end

  // Response monitor: every pulse must match the queue head
  always @(negedge clk) begin
    if (!rst && rsp_valid != 0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=%b, required none",
                 rsp_valid);
      end else begin
        mon_e = sb.pop_front();
        if (rsp_valid !== (4'(1) << mon_e.idx) ||
            rsp_rdata !== mon_e.rdata ||
            rsp_resp !== mon_e.resp ||
            rsp_timeout !== mon_e.to) begin
          errors++;
          $display("FAIL rsp: got v=%b d=%h r=%b t=%b, required v=%b d=%h r=%b t=%b",
                   rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
                   4'(1) << mon_e.idx, mon_e.rdata, mon_e.resp, mon_e.to);
        end
      end
    end
  end

  function automatic exp_t mk(int i, logic [31:0] d,
                              logic [1:0] r, logic t);
    exp_t e;
    e.idx = i; e.rdata = d; e.resp = r; e.to = t;
    return e;
  endfunction

  // Called on a falling edge; returns on the one showing req_ready
  task automatic issue(input int i, input bit we,
                       input logic [31:0] a,
                       input logic [31:0] d, output int lat);
    lat = 0;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_valid[i] = 1'b1;
    do begin
      @(negedge clk); lat++;
    end while (!req_ready[i] && lat < 100);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i, output int lat);
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (!rsp_valid[i] && lat < 200);
  endtask

  task automatic drain(input string nm);
    int c = 0;
    while (sb.size() != 0 && c < 100) begin
      @(negedge clk); c++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending, required 0",
               nm, sb.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({axi.awvalid, axi.wvalid, axi.arvalid,
         axi.bready, axi.rready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_axi: got %b, required 00000",
               {axi.awvalid, axi.wvalid, axi.arvalid,
                axi.bready, axi.rready});
    end
    checks++;
    if (req_ready !== 0 || rsp_valid !== 0 ||
        rsp_timeout !== 0) begin
      errors++;
      $display("FAIL reset_req: got rdy=%b v=%b t=%b, required 0",
               req_ready, rsp_valid, rsp_timeout);
    end
    checks++;
    if (rsp_rdata !== 0 || rsp_resp !== 0) begin
      errors++;
      $display("FAIL reset_rsp: got d=%h r=%b, required 0",
               rsp_rdata, rsp_resp);
    end
    rst = 1'b0;
  endtask

  task automatic test_round_robin;
    int order[5] = '{0, 1, 2, 3, 0};
    int n = 0, cyc = 0, last_g = 0;
    bit re0 = 0;
    for (int i = 0; i < N; i++) begin
      sb.push_back(mk(i, 0, 2'b00, 1'b0));
      req_we[i] = 1'b1;
      req_addr[i*AW +: AW] = 32'h20 + 32'(4 * i);
      req_wdata[i*DW +: DW] = 32'h100 + 32'(i);
      req_valid[i] = 1'b1;
    end
    while (n < 5 && cyc < 100) begin
      @(negedge clk); cyc++;
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] && n < 5) begin
          checks++;
          if (i != order[n]) begin
            errors++;
            $display("FAIL rr_order: got %0d, required %0d",
                     i, order[n]);
          end
          if (n > 0) begin
            checks++;
            if (cyc - last_g != 3) begin
              errors++;
              $display("FAIL rr_gap: got %0d, required 3",
                       cyc - last_g);
            end
          end
          last_g = cyc;
          n++;
          if (i == 0 && !re0) begin
            re0 = 1;
            sb.push_back(mk(0, 0, 2'b00, 1'b0));
          end else req_valid[i] = 1'b0;
        end
      end
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL rr_grants: got %0d, required 5", n);
    end
    req_valid = '0;
    drain("rr");
  endtask

  task automatic test_write_read;
    int lat;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        sb.push_back(mk(0, r ? 32'(k + 1) : 0, 2'b00, 1'b0));
        issue(0, r == 0, 32'(4 * k), 32'(k + 1), lat);
        checks++;
        if (lat != 1) begin
          errors++;
          $display("FAIL wr_grant_lat: got %0d, required 1", lat);
        end
        checks++;
        if ((r == 0 && !(axi.awvalid && axi.wvalid)) ||
            (r == 1 && !axi.arvalid)) begin
          errors++;
          $display("FAIL wr_valid: got aw=%b w=%b ar=%b, required set",
                   axi.awvalid, axi.wvalid, axi.arvalid);
        end
        wait_rsp(0, lat);
        checks++;
        if (lat != 2) begin
          errors++;
          $display("FAIL wr_rsp_lat: got %0d, required 2", lat);
        end
      end
    end
    drain("wr");
  endtask

  task automatic test_aw_stall;
    int lat, aw_c, w_c, b0, c;
    aw_delay = 5;
    b0 = b_count;
    sb.push_back(mk(1, 0, 2'b00, 1'b0));
    issue(1, 1'b1, 32'h10, 32'hAA, lat);
    aw_c = int'(axi.awvalid);
    w_c  = int'(axi.wvalid);
    c = 0;
    while (!rsp_valid[1] && c < 50) begin
      @(negedge clk); c++;
      aw_c += int'(axi.awvalid);
      w_c  += int'(axi.wvalid);
    end
    checks++;
    if (w_c != 1) begin
      errors++;
      $display("FAIL stall_wvalid: got %0d, required 1", w_c);
    end
    checks++;
    if (aw_c != aw_delay + 1) begin
      errors++;
      $display("FAIL stall_awvalid: got %0d, required %0d",
               aw_c, aw_delay + 1);
    end
    checks++;
    if (b_count - b0 != 1) begin
      errors++;
      $display("FAIL stall_b: got %0d, required 1", b_count - b0);
    end
    aw_delay = 0;
    drain("stall");
  endtask

  task automatic test_timeout;
    int lat, b0, c;
    b_delay = 40;
    b0 = b_count;
    sb.push_back(mk(2, 0, 2'b10, 1'b1));
    issue(2, 1'b1, 32'h14, 32'h55, lat);
    wait_rsp(2, lat);
    checks++;
    if (lat + 1 < 16 || lat + 1 > 18) begin
      errors++;
      $display("FAIL tmo_lat: got %0d, required 16..18", lat + 1);
    end
    checks++;
    if (b_count != b0) begin
      errors++;
      $display("FAIL tmo_early_b: got %0d, required %0d",
               b_count, b0);
    end
    c = 0;
    while (b_count == b0 && c < 60) begin
      @(negedge clk); c++;
    end
    checks++;
    if (b_count - b0 != 1) begin
      errors++;
      $display("FAIL tmo_late_b: got %0d, required 1",
               b_count - b0);
    end
    b_delay = 0;
    repeat (3) @(negedge clk);
    sb.push_back(mk(2, 32'h55, 2'b00, 1'b0));
    issue(2, 1'b0, 32'h14, 0, lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL tmo_idle: got %0d, required 1", lat);
    end
    drain("tmo");
  endtask

  task automatic test_rresp_err;
    int lat;
    rresp_cfg = 2'b10;
    sb.push_back(mk(3, 32'h3, 2'b10, 1'b0));
    issue(3, 1'b0, 32'h8, 0, lat);
    wait_rsp(3, lat);
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL rresp_lat: got %0d, required 2", lat);
    end
    rresp_cfg = 2'b00;
    drain("rresp");
  endtask

  task automatic test_reset_mid;
    int lat, c, first;
    r_delay = 20;
    issue(1, 1'b0, 32'h0, 0, lat);
    c = 0;
    while (!axi.rready && c < 10) begin
      @(negedge clk); c++;
    end
    checks++;
    if (!axi.rready) begin
      errors++;
      $display("FAIL rst_mid_rdata: got rready=0, required 1");
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({axi.awvalid, axi.wvalid, axi.arvalid,
         axi.bready, axi.rready, req_ready,
         rsp_valid} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outs: got %b, required 0",
               {axi.awvalid, axi.wvalid, axi.arvalid,
                axi.bready, axi.rready, req_ready, rsp_valid});
    end
    rst = 1'b0;
    r_delay = 0;
    sb.push_back(mk(0, 32'h1, 2'b00, 1'b0));
    sb.push_back(mk(2, 32'h2, 2'b00, 1'b0));
    req_we[0] = 0; req_addr[0 +: AW] = 32'h0;
    req_we[2] = 0; req_addr[2*AW +: AW] = 32'h4;
    req_valid[0] = 1; req_valid[2] = 1;
    first = -1; c = 0;
    while (req_valid != 0 && c < 50) begin
      @(negedge clk); c++;
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          if (first < 0) first = i;
          req_valid[i] = 1'b0;
        end
      end
    end
    checks++;
    if (first != 0) begin
      errors++;
      $display("FAIL rst_mid_first: got %0d, required 0", first);
    end
    req_valid = '0;
    drain("rst_mid");
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_round_robin();
    test_write_read();
    test_aw_stall();
    test_timeout();
    test_rresp_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
